// File: rtl/cdc_pkg.sv
// Shared definitions for the fast-to-slow pulse path: throttle FSM encoding and
// a legality check on the replay spacing.
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic bit min_gap_ok(input int gap);
    return gap >= 2;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter; an increment arriving while the count sits at
// sat_max with no decrement is refused and reported on o_drop.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] sat_max,
  output logic [W-1:0] o_cnt,
  output logic         o_drop
);

  logic [W-1:0] cnt;
  logic         inc_ok;

  assign o_drop = inc && (cnt == sat_max) && !dec;
  assign inc_ok = inc && !o_drop;
  assign o_cnt  = cnt;

  // Simultaneous accepted increment and decrement cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (inc_ok && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (!inc_ok && dec) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_event_throttle.sv
// Buffers bursty single-cycle events and replays them as pulses spaced exactly
// MIN_GAP cycles apart, so the downstream req/ack synchronizer is never overrun.
module pulse_event_throttle
  import cdc_pkg::*;
#(
  parameter  int CNT_W   = 4,
  parameter  int MIN_GAP = 8,
  localparam int GAP_W   = $clog2(MIN_GAP)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_event,
  input  logic             i_ovf_clr,
  output logic             o_pulse,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

  if (!min_gap_ok(MIN_GAP)) begin : g_bad_min_gap
    $error("pulse_event_throttle: MIN_GAP must be at least 2");
  end

  state_e           state;
  logic [GAP_W-1:0] gap;
  logic [CNT_W-1:0] cnt;
  logic             work;
  logic             fire;
  logic             drop;

  // A new event can be fired in the very cycle it arrives, so the counter
  // sees inc and dec together and stays put.
  assign work = (cnt != '0) || i_event;
  assign fire = work && ((state == ST_IDLE) || ((state == ST_GAP) && (gap == '0)));

  sat_updown_cnt #(.W(CNT_W)) u_pending (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .inc     (i_event),
    .dec     (fire),
    .sat_max (CNT_MAX),
    .o_cnt   (cnt),
    .o_drop  (drop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      gap        <= '0;
      o_pulse    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_pulse <= fire;
      case (state)
        ST_IDLE: if (fire) state <= ST_FIRE;
        ST_FIRE: begin
          gap   <= GAP_LOAD;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (gap != '0) begin
            gap <= gap - 1'b1;
          end else if (fire) begin
            state <= ST_FIRE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        o_overflow <= 1'b0;
      end
    end
  end

  assign o_pending = cnt;
  assign o_busy    = (state != ST_IDLE) || (cnt != '0);

endmodule
